// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle.
// Raises a stall request to EX until {remainder, quotient} is ready.
module div_seq #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                annul_i,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o,
   output logic                stallreq_o
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rem;
   logic [DATA_W-1:0]   r_dvd;
   logic [DATA_W-1:0]   r_dvs;
   logic                r_neg1;
   logic                r_neg2;
   logic [2*DATA_W-1:0] r_result;
   logic                r_ready;

   logic                w_neg1;
   logic                w_neg2;
   logic [DATA_W-1:0]   w_abs1;
   logic [DATA_W-1:0]   w_abs2;
   logic [DATA_W:0]     w_shift;
   logic                w_ge;
   logic [DATA_W-1:0]   w_diff;
   logic [DATA_W-1:0]   w_quot_fix;
   logic [DATA_W-1:0]   w_rem_fix;
   logic                w_last;

   assign w_neg1 = signed_div_i & opdata1_i[DATA_W-1];
   assign w_neg2 = signed_div_i & opdata2_i[DATA_W-1];
   assign w_abs1 = w_neg1 ? ('0 - opdata1_i) : opdata1_i;
   assign w_abs2 = w_neg2 ? ('0 - opdata2_i) : opdata2_i;

   // Partial remainder stays below the divisor, so the low DATA_W bits of the difference are exact.
   assign w_shift    = {r_rem, r_dvd[DATA_W-1]};
   assign w_ge       = (w_shift >= {1'b0, r_dvs});
   assign w_diff     = w_shift[DATA_W-1:0] - r_dvs;
   assign w_quot_fix = (r_neg1 ^ r_neg2) ? ('0 - r_dvd) : r_dvd;
   assign w_rem_fix  = r_neg1 ? ('0 - r_rem) : r_rem;
   assign w_last     = (r_cnt == CNT_W'(DATA_W));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FREE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FREE:   if (start_i && !annul_i) w_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
         S_BYZERO: w_next = S_END;
         S_ON: begin
            if (annul_i)     w_next = S_FREE;
            else if (w_last) w_next = S_END;
         end
         S_END:    if (!start_i || annul_i) w_next = S_FREE;
         default:  w_next = S_FREE;
      endcase
   end

   always_comb begin
      result_o   = r_result;
      ready_o    = r_ready;
      stallreq_o = start_i & ~r_ready & ~annul_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_dvd    <= '0;
         r_dvs    <= '0;
         r_neg1   <= 1'b0;
         r_neg2   <= 1'b0;
         r_result <= '0;
         r_ready  <= 1'b0;
      end else begin
         case (r_state)
            S_FREE: begin
               if (start_i && !annul_i) begin
                  r_cnt  <= '0;
                  r_rem  <= '0;
                  r_dvd  <= w_abs1;
                  r_dvs  <= w_abs2;
                  r_neg1 <= w_neg1;
                  r_neg2 <= w_neg2;
               end
            end
            S_BYZERO: begin
               r_result <= '0;
               r_ready  <= 1'b1;
            end
            S_ON: begin
               if (!annul_i) begin
                  if (w_last) begin
                     r_result <= {w_rem_fix, w_quot_fix};
                     r_ready  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                     r_rem <= w_ge ? w_diff : w_shift[DATA_W-1:0];
                     r_dvd <= {r_dvd[DATA_W-2:0], w_ge};
                  end
               end
            end
            S_END: begin
               if (!start_i || annul_i) begin
                  r_result <= '0;
                  r_ready  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed divides with hand-computed results,
// latency, stall, hold, annul and asynchronous reset checks.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i, annul_i, signed_div_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic [63:0] result_o;
   logic        ready_o, stallreq_o;

   div_seq #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
      .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
      .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      int          lat;
      string       nm;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   t_accept = 0;
   logic mon_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every rising ready_o must match the oldest expected result.
   always @(negedge clk) begin
      if (ready_o && !mon_prev) begin
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ready: got result %h expected no result", result_o);
         end else begin
            mon_e = sbq.pop_front();
            check({mon_e.nm, "_result"}, result_o, mon_e.res);
            check({mon_e.nm, "_latency"}, 64'(cyc - t_accept), 64'(mon_e.lat));
         end
      end
      mon_prev <= ready_o;
   end

   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input int hold,
                         input bit release_start, input string nm);
      int stall;
      exp_t e;
      @(negedge clk);
      start_i = 1'b1; annul_i = 1'b0; signed_div_i = sgn;
      opdata1_i = a; opdata2_i = b;
      e.res = exp; e.lat = lat; e.nm = nm;
      sbq.push_back(e);
      @(posedge clk); #1;
      t_accept = cyc;
      opdata1_i = 32'h5A5A_A5A5; opdata2_i = 32'h0000_0003; signed_div_i = ~sgn;
      stall = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (ready_o) break;
         if (stallreq_o) stall++;
      end
      check({nm, "_ready_seen"}, 64'(ready_o), 64'd1);
      check({nm, "_stall_cycles"}, 64'(stall), 64'(lat));
      check({nm, "_stall_drop"}, 64'(stallreq_o), 64'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({nm, "_hold_ready"}, 64'(ready_o), 64'd1);
         check({nm, "_hold_result"}, result_o, exp);
      end
      if (release_start) begin
         start_i = 1'b0;
         @(negedge clk);
         check({nm, "_drop_ready"}, 64'(ready_o), 64'd0);
         check({nm, "_drop_result"}, result_o, 64'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = '0; opdata2_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_ready", 64'(ready_o), 64'd0);
      check("reset_result", result_o, 64'd0);
      check("reset_stall", 64'(stallreq_o), 64'd0);

      do_div(1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 0, 1'b1, "divu_100_7");
      do_div(1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 0, 1'b1, "div_m7_2");
      do_div(1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 0, 1'b1, "div_7_m2");
      do_div(1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 33, 0, 1'b1, "div_m7_m2");
      do_div(1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33, 0, 1'b1, "divu_big_2");
      do_div(1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, 0, 1'b1, "divu_max_1");

      // Signed overflow case, then async reset while holding in END.
      do_div(1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 2, 1'b0, "div_min_m1");
      #2 rst = 1'b1;
      #1;
      check("rst_end_ready", 64'(ready_o), 64'd0);
      check("rst_end_result", result_o, 64'd0);
      check("rst_end_stall", 64'(stallreq_o), 64'd1);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      do_div(1'b0, 32'd1234,       32'd0,          64'd0, 1, 5, 1'b1, "divu_by_zero");

      // Annul at cnt=10; no result may appear.
      @(negedge clk);
      start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      #1;
      check("annul_stall", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      check("annul_ready", 64'(ready_o), 64'd0);
      do_div(1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 33, 0, 1'b1, "divu_9_3");

      // Async reset mid-ON at cnt=20.
      @(negedge clk);
      start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7;
      @(posedge clk);
      repeat (20) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_on_ready", 64'(ready_o), 64'd0);
      check("rst_on_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      do_div(1'b0, 32'd50,         32'd5,          64'h00000000_0000000A, 33, 0, 1'b1, "divu_50_5");

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
